// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the pipeline execution controller.
package run_ctrl_pkg;

  typedef logic [2:0] cmd_op_t;
  typedef logic [1:0] state_t;

  // Debug command opcodes; 3'd7 is reserved and decodes to nothing.
  localparam cmd_op_t CMD_NOP     = 3'd0;
  localparam cmd_op_t CMD_RUN     = 3'd1;
  localparam cmd_op_t CMD_STEP    = 3'd2;
  localparam cmd_op_t CMD_HALT    = 3'd3;
  localparam cmd_op_t CMD_SET_BP  = 3'd4;
  localparam cmd_op_t CMD_CLR_BP  = 3'd5;
  localparam cmd_op_t CMD_CLR_CNT = 3'd6;

  // Controller states.
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_STEP  = 2'd2;
  localparam state_t S_DRAIN = 2'd3;

  // Bubbles needed to retire everything in flight behind a stop.
  localparam int unsigned DRAIN_CYCLES_DEF = 4;

  // True when a handshake completes carrying the wanted opcode.
  function automatic logic cmd_is(input logic accepted, input cmd_op_t op,
                                  input cmd_op_t want);
    return accepted && (op == want);
  endfunction

endpackage

// File: rtl/bp_compare.sv
// PC breakpoint register with equality compare. The match is masked for the
// first execution cycle after leaving IDLE so resuming at the breakpoint PC
// does not immediately re-trigger.
module bp_compare #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_bp,
  input  logic            clr_bp,
  input  logic [PC_W-1:0] set_addr,
  input  logic            launch,
  input  logic [PC_W-1:0] pc,
  output logic            match
);

  logic [PC_W-1:0] bp_addr;
  logic            bp_en;
  logic            bp_mask;

  // Breakpoint address/enable updated by SET_BP / CLR_BP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_addr <= '0;
      bp_en   <= 1'b0;
    end else if (set_bp) begin
      bp_addr <= set_addr;
      bp_en   <= 1'b1;
    end else if (clr_bp) begin
      bp_en   <= 1'b0;
    end
  end

  // Mask is high only in the cycle following a launch out of IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bp_mask <= 1'b0;
    else       bp_mask <= launch;
  end

  // Qualified breakpoint hit.
  always_comb begin
    match = bp_en && (pc == bp_addr) && !bp_mask;
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Execution controller for the 5-stage pipeline: gates the latch enable and
// sequences run, N-step, halt and drain, with breakpoint/halt-instruction
// stops and a debug cycle counter.
module pipeline_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_arg,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             halt_instr,
  output logic             pipe_en,
  output logic             pipe_flush,
  output logic             halted,
  output logic             bp_hit,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  state_t          state, state_n;
  logic [CNT_W-1:0] step_cnt, step_n;
  logic [DW-1:0]    drain_cnt, drain_n;
  logic             hit_n, done_n;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] arg_cnt;

  logic accepted, acc_run, acc_step, acc_halt, acc_set, acc_clrbp, acc_clrcnt;
  logic launch, bp_match, stop_evt;

  // Moore outputs decoded from the registered state.
  always_comb begin
    pipe_en    = (state != S_IDLE);
    pipe_flush = (state == S_DRAIN);
    halted     = (state == S_IDLE);
    cmd_ready  = (state != S_DRAIN);
    cycle_cnt  = cycle_q;
  end

  // Command decode; DRAIN drops cmd_ready so commands stall there.
  always_comb begin
    accepted   = cmd_valid && cmd_ready;
    acc_run    = cmd_is(accepted, cmd_op, CMD_RUN);
    acc_step   = cmd_is(accepted, cmd_op, CMD_STEP);
    acc_halt   = cmd_is(accepted, cmd_op, CMD_HALT);
    acc_set    = cmd_is(accepted, cmd_op, CMD_SET_BP);
    acc_clrbp  = cmd_is(accepted, cmd_op, CMD_CLR_BP);
    acc_clrcnt = cmd_is(accepted, cmd_op, CMD_CLR_CNT);
    arg_cnt    = cmd_arg[CNT_W-1:0];
    launch     = (state == S_IDLE) && (acc_run || acc_step);
    stop_evt   = bp_match || halt_instr;
  end

  bp_compare #(
    .PC_W(PC_W)
  ) u_bp (
    .clk      (clk),
    .reset    (reset),
    .set_bp   (acc_set),
    .clr_bp   (acc_clrbp),
    .set_addr (cmd_arg[PC_W-1:0]),
    .launch   (launch),
    .pc       (if_pc),
    .match    (bp_match)
  );

  // Next-state logic; a stop event outranks HALT and step expiry.
  always_comb begin
    state_n = state;
    step_n  = step_cnt;
    drain_n = drain_cnt;
    hit_n   = bp_hit;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc_run) begin
          state_n = S_RUN;
          hit_n   = 1'b0;
        end else if (acc_step) begin
          state_n = S_STEP;
          step_n  = (arg_cnt == '0) ? CNT_W'(1) : arg_cnt;
          hit_n   = 1'b0;
        end
      end
      S_RUN: begin
        if (stop_evt) begin
          state_n = S_DRAIN;
          drain_n = DW'(DRAIN_CYCLES);
          hit_n   = 1'b1;
        end else if (acc_halt) begin
          state_n = S_DRAIN;
          drain_n = DW'(DRAIN_CYCLES);
        end
      end
      S_STEP: begin
        step_n = step_cnt - CNT_W'(1);
        if (stop_evt) begin
          state_n = S_DRAIN;
          drain_n = DW'(DRAIN_CYCLES);
          hit_n   = 1'b1;
        end else if (acc_halt) begin
          state_n = S_IDLE;
        end else if (step_cnt == CNT_W'(1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      S_DRAIN: begin
        drain_n = drain_cnt - DW'(1);
        if (drain_cnt == DW'(1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and sequencing registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      step_cnt  <= '0;
      drain_cnt <= '0;
      bp_hit    <= 1'b0;
      step_done <= 1'b0;
    end else begin
      state     <= state_n;
      step_cnt  <= step_n;
      drain_cnt <= drain_n;
      bp_hit    <= hit_n;
      step_done <= done_n;
    end
  end

  // Executed-cycle counter; CLR_CNT wins over the same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cycle_q <= '0;
    else if (acc_clrcnt)             cycle_q <= '0;
    else if (pipe_en && !pipe_flush) cycle_q <= cycle_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: a vector table for the main
// step/run/breakpoint/drain flow plus hand sequences for corner cases.
module tb_pipeline_run_ctrl;
  import run_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] if_pc;
  logic        halt_instr;
  logic        pipe_en, pipe_flush, halted, bp_hit, step_done;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_run_ctrl #(
    .PC_W(32),
    .CNT_W(32),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .if_pc      (if_pc),
    .halt_instr (halt_instr),
    .pipe_en    (pipe_en),
    .pipe_flush (pipe_flush),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .step_done  (step_done),
    .cycle_cnt  (cycle_cnt)
  );

  typedef struct {
    logic        vld;
    logic [2:0]  op;
    logic [31:0] arg;
    logic [31:0] pc;
    logic        hi;
    logic        en, fl, hl, rdy, hit, sd;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic vld, input logic [2:0] op,
                              input logic [31:0] arg, input logic [31:0] pc,
                              input logic hi, input logic en, input logic fl,
                              input logic hl, input logic rdy, input logic hit,
                              input logic sd, input logic [31:0] cnt);
    vec_t v;
    v.vld = vld; v.op = op; v.arg = arg; v.pc = pc; v.hi = hi;
    v.en = en; v.fl = fl; v.hl = hl; v.rdy = rdy; v.hit = hit; v.sd = sd;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [31:0] arg, input logic [31:0] pc,
                       input logic hi);
    cmd_valid  = v;
    cmd_op     = op;
    cmd_arg    = arg;
    if_pc      = pc;
    halt_instr = hi;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nfl;
    logic rdy_bad;

    // idle / step 3 / step 0 / run into breakpoint / resume / HALT drain
    tbl[0]  = mk(1, CMD_SET_BP, 32'h40, 32'h0,  0, 0,0,1,1,0,0, 0);
    tbl[1]  = mk(1, CMD_STEP,   32'd3,  32'h0,  0, 0,0,1,1,0,0, 0);
    tbl[2]  = mk(0, CMD_NOP,    32'd0,  32'h0,  0, 1,0,0,1,0,0, 0);
    tbl[3]  = mk(0, CMD_NOP,    32'd0,  32'h0,  0, 1,0,0,1,0,0, 1);
    tbl[4]  = mk(0, CMD_NOP,    32'd0,  32'h0,  0, 1,0,0,1,0,0, 2);
    tbl[5]  = mk(0, CMD_NOP,    32'd0,  32'h0,  0, 0,0,1,1,0,1, 3);
    tbl[6]  = mk(1, CMD_STEP,   32'd0,  32'h0,  0, 0,0,1,1,0,0, 3);
    tbl[7]  = mk(0, CMD_NOP,    32'd0,  32'h0,  0, 1,0,0,1,0,0, 3);
    tbl[8]  = mk(0, CMD_NOP,    32'd0,  32'h0,  0, 0,0,1,1,0,1, 4);
    tbl[9]  = mk(1, CMD_RUN,    32'd0,  32'h30, 0, 0,0,1,1,0,0, 4);
    tbl[10] = mk(0, CMD_NOP,    32'd0,  32'h38, 0, 1,0,0,1,0,0, 4);
    tbl[11] = mk(0, CMD_NOP,    32'd0,  32'h3C, 0, 1,0,0,1,0,0, 5);
    tbl[12] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 1,0,0,1,0,0, 6);
    tbl[13] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 1,1,0,0,1,0, 7);
    tbl[14] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 1,1,0,0,1,0, 7);
    tbl[15] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 1,1,0,0,1,0, 7);
    tbl[16] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 1,1,0,0,1,0, 7);
    tbl[17] = mk(1, CMD_RUN,    32'd0,  32'h40, 0, 0,0,1,1,1,0, 7);
    tbl[18] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 1,0,0,1,0,0, 7);
    tbl[19] = mk(0, CMD_NOP,    32'd0,  32'h44, 0, 1,0,0,1,0,0, 8);
    tbl[20] = mk(1, CMD_CLR_BP, 32'd0,  32'h44, 0, 1,0,0,1,0,0, 9);
    tbl[21] = mk(1, CMD_HALT,   32'd0,  32'h40, 0, 1,0,0,1,0,0, 10);
    tbl[22] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 1,1,0,0,0,0, 11);
    tbl[23] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 1,1,0,0,0,0, 11);
    tbl[24] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 1,1,0,0,0,0, 11);
    tbl[25] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 1,1,0,0,0,0, 11);
    tbl[26] = mk(0, CMD_NOP,    32'd0,  32'h40, 0, 0,0,1,1,0,0, 11);

    // Reset values
    reset = 1'b1;
    drive(0, CMD_NOP, 0, 0, 0);
    #1;
    chk("rst pipe_en",    32'(pipe_en),    0);
    chk("rst pipe_flush", 32'(pipe_flush), 0);
    chk("rst halted",     32'(halted),     1);
    chk("rst cmd_ready",  32'(cmd_ready),  1);
    chk("rst bp_hit",     32'(bp_hit),     0);
    chk("rst step_done",  32'(step_done),  0);
    chk("rst cycle_cnt",  cycle_cnt,       0);
    chk("rst bp_en",      32'(dut.u_bp.bp_en), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Vector table: outputs reflect state before the edge that consumes inputs
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].op, tbl[i].arg, tbl[i].pc, tbl[i].hi);
      chk($sformatf("v%0d pipe_en", i),    32'(pipe_en),    32'(tbl[i].en));
      chk($sformatf("v%0d pipe_flush", i), 32'(pipe_flush), 32'(tbl[i].fl));
      chk($sformatf("v%0d halted", i),     32'(halted),     32'(tbl[i].hl));
      chk($sformatf("v%0d cmd_ready", i),  32'(cmd_ready),  32'(tbl[i].rdy));
      chk($sformatf("v%0d bp_hit", i),     32'(bp_hit),     32'(tbl[i].hit));
      chk($sformatf("v%0d step_done", i),  32'(step_done),  32'(tbl[i].sd));
      chk($sformatf("v%0d cycle_cnt", i),  cycle_cnt,       tbl[i].cnt);
    end

    // Seq A: halt_instr and HALT together -> one drain; HALT during drain stalls
    @(negedge clk); drive(1, CMD_CLR_CNT, 0, 0, 0);
    @(negedge clk); drive(1, CMD_RUN, 0, 0, 0);
    @(negedge clk); drive(0, CMD_NOP, 0, 0, 0);
    chk("A run pipe_en", 32'(pipe_en), 1);
    chk("A run cnt0", cycle_cnt, 0);
    @(negedge clk); drive(1, CMD_HALT, 0, 0, 1);
    chk("A run cnt1", cycle_cnt, 1);
    @(negedge clk); drive(1, CMD_HALT, 0, 0, 0);
    chk("A drain flush", 32'(pipe_flush), 1);
    chk("A drain ready", 32'(cmd_ready), 0);
    chk("A drain bp_hit", 32'(bp_hit), 1);
    nfl = 1;
    rdy_bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!pipe_flush) break;
      nfl++;
      if (cmd_ready) rdy_bad = 1'b1;
    end
    chk("A flush cycles", 32'(nfl), 4);
    chk("A ready low in drain", 32'(rdy_bad), 0);
    chk("A idle after drain", 32'(halted), 1);
    chk("A ready in idle", 32'(cmd_ready), 1);
    chk("A cnt frozen", cycle_cnt, 2);
    @(negedge clk); drive(0, CMD_NOP, 0, 0, 0);
    chk("A halt no-op halted", 32'(halted), 1);
    chk("A halt no-op en", 32'(pipe_en), 0);
    chk("A halt no-op bp_hit", 32'(bp_hit), 1);

    // Seq B: STEP 5, HALT on 2nd step cycle -> IDLE, no drain, no step_done
    @(negedge clk); drive(1, CMD_CLR_CNT, 0, 0, 0);
    @(negedge clk); drive(1, CMD_STEP, 5, 0, 0);
    @(negedge clk); drive(0, CMD_NOP, 0, 0, 0);
    @(negedge clk); drive(1, CMD_HALT, 0, 0, 0);
    chk("B step2 en", 32'(pipe_en), 1);
    @(negedge clk); drive(0, CMD_NOP, 0, 0, 0);
    chk("B halted", 32'(halted), 1);
    chk("B no flush", 32'(pipe_flush), 0);
    chk("B no step_done", 32'(step_done), 0);
    chk("B cnt", cycle_cnt, 2);
    chk("B bp_hit cleared", 32'(bp_hit), 0);
    @(negedge clk);
    chk("B still halted", 32'(halted), 1);
    chk("B no step_done late", 32'(step_done), 0);

    // Seq C: counter wrap and CLR_CNT priority during RUN
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    chk("C preload", cycle_cnt, 32'hFFFF_FFFF);
    drive(1, CMD_RUN, 0, 0, 0);
    @(negedge clk); drive(1, CMD_HALT, 0, 0, 0);
    @(negedge clk); drive(0, CMD_NOP, 0, 0, 0);
    chk("C wrap", cycle_cnt, 0);
    chk("C wrap drain", 32'(pipe_flush), 1);
    for (int i = 0; i < 10; i++) begin
      if (halted) break;
      @(negedge clk);
    end
    chk("C back idle", 32'(halted), 1);
    drive(1, CMD_RUN, 0, 0, 0);
    @(negedge clk); drive(0, CMD_NOP, 0, 0, 0);
    @(negedge clk); drive(1, CMD_CLR_CNT, 0, 0, 0);
    chk("C pre-clr", cycle_cnt, 1);
    @(negedge clk); drive(0, CMD_NOP, 0, 0, 0);
    chk("C clr priority", cycle_cnt, 0);
    @(negedge clk);
    chk("C incr after clr", cycle_cnt, 1);
    @(negedge clk); drive(1, CMD_HALT, 0, 0, 0);
    @(negedge clk); drive(0, CMD_NOP, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (halted) break;
      @(negedge clk);
    end

    // Seq D: reset mid-RUN aborts immediately
    @(negedge clk); drive(1, CMD_SET_BP, 32'h1000, 0, 0);
    @(negedge clk); drive(1, CMD_CLR_CNT, 0, 0, 0);
    @(negedge clk); drive(1, CMD_RUN, 0, 0, 0);
    @(negedge clk); drive(0, CMD_NOP, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      if (cycle_cnt == 32'd57) break;
      @(negedge clk);
    end
    chk("D reached 57", cycle_cnt, 57);
    chk("D running", 32'(pipe_en), 1);
    reset = 1'b1;
    #1;
    chk("D rst pipe_en", 32'(pipe_en), 0);
    chk("D rst halted", 32'(halted), 1);
    chk("D rst cycle_cnt", cycle_cnt, 0);
    chk("D rst bp_en", 32'(dut.u_bp.bp_en), 0);
    chk("D rst flush", 32'(pipe_flush), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("D post halted", 32'(halted), 1);
    chk("D post ready", 32'(cmd_ready), 1);
    chk("D post en", 32'(pipe_en), 0);
    chk("D post cnt", cycle_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
